// File: rtl/aes_decrypt_iterative.sv
// AES-128 inverse cipher, one round per clock, valid/ready handshake on both sides.
// Optional macro AES_DEC_KEY_LATCH_EN: capture rk[0..9] at accept so key_schedule may change afterwards.
module aes_decrypt_iterative #(
    parameter int NR      = 10,
    parameter int KS_BITS = (NR + 1) * 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:127]       in_state,
    input  logic [0:KS_BITS-1] key_schedule,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:127]       o_state,
    output logic               busy
);
    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_9(input logic [7:0] a);
        return xt(xt(xt(a))) ^ a;
    endfunction

    function automatic logic [7:0] mul_b(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(a) ^ a;
    endfunction

    function automatic logic [7:0] mul_d(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
    endfunction

    function automatic logic [7:0] mul_e(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
    endfunction

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [0:127] state_q, state_d;
    logic [0:127] o_state_q, o_state_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;
    logic [0:127] rk_cur;
    logic [0:127] t_vec;
    logic [0:127] mc_vec;
    logic [7:0]   t_b [16];
    logic         accept;

    assign accept = (fsm_q == IDLE) && in_ready_q && in_valid;

`ifdef AES_DEC_KEY_LATCH_EN
    logic [0:NR*128-1] rk_q, rk_d;

    assign rk_d   = accept ? key_schedule[0:NR*128-1] : rk_q;
    assign rk_cur = rk_q[{rnd_q, 7'b0} +: 128];

    always_ff @(posedge clk) begin
        rk_q <= rk_d;
    end
`else
    assign rk_cur = key_schedule[{rnd_q, 7'b0} +: 128];
`endif

    // Byte gi sits at row gi%4, column gi/4; InvShiftRows pulls from column (c - r) mod 4.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_byte
            localparam int R   = gi % 4;
            localparam int C   = gi / 4;
            localparam int SRC = 4 * ((C - R + 4) % 4) + R;
            assign t_b[gi]            = inv_sbox(state_q[8*SRC +: 8]) ^ rk_cur[8*gi +: 8];
            assign t_vec[8*gi +: 8]   = t_b[gi];
            assign mc_vec[8*gi +: 8]  = mul_e(t_b[4*C + R]) ^ mul_b(t_b[4*C + (R + 1) % 4])
                                      ^ mul_d(t_b[4*C + (R + 2) % 4]) ^ mul_9(t_b[4*C + (R + 3) % 4]);
        end
    endgenerate

    always_comb begin
        fsm_d     = fsm_q;
        rnd_d     = rnd_q;
        state_d   = state_q;
        o_state_d = o_state_q;
        case (fsm_q)
            IDLE: begin
                if (accept) begin
                    state_d = in_state ^ key_schedule[NR*128 +: 128];
                    rnd_d   = 4'(NR - 1);
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                if (rnd_q != 4'd0) begin
                    state_d = mc_vec;
                    rnd_d   = rnd_q - 4'd1;
                end else begin
                    state_d   = t_vec;
                    o_state_d = t_vec;
                    fsm_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
        in_ready_d  = (fsm_d == IDLE);
        out_valid_d = (fsm_d == DONE);
        busy_d      = (fsm_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            rnd_q       <= 4'd0;
            state_q     <= '0;
            o_state_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            rnd_q       <= rnd_d;
            state_q     <= state_d;
            o_state_q   <= o_state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign o_state   = o_state_q;
    assign busy      = busy_q;
endmodule
